// File: rtl/bin_to_7seg_scan.sv
// Binary to multi-digit 7-segment driver: iterative shift-add-3 BCD conversion
// with start/done handshake, overflow dashes, leading-zero blanking and digit scanning.
module bin_to_7seg_scan #(
   parameter int WIDTH   = 8,
   parameter int DIGITS  = 3,
   parameter int REFRESH = 50000,
   parameter int LZB     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(REFRESH);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    scratch_q, scratch_d, adj;
   logic             ovf_s_q, ovf_s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic [RW-1:0]    ref_q, ref_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [6:0]       seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [3:0]       nib;
   logic [6:0]       pat;
   logic             blank;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      scratch_d = scratch_q;
      ovf_s_d   = ovf_s_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      adj       = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shreg_d   = bin;
               scratch_d = '0;
               ovf_s_d   = 1'b0;
               cnt_d     = CW'(WIDTH);
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // A bit leaving the top nibble means the value needs another digit.
            scratch_d = {adj[BW-2:0], shreg_q[WIDTH-1]};
            shreg_d   = shreg_q << 1;
            ovf_s_d   = ovf_s_q | adj[BW-1];
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FINISH;
         end
         S_FINISH: begin
            bcd_d   = scratch_q;
            ovf_d   = ovf_s_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ref_d = ref_q + RW'(1);
      idx_d = idx_q;
      if (ref_q == RW'(REFRESH - 1)) begin
         ref_d = '0;
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
      nib = bcd_q[{idx_q, 2'b00} +: 4];
      case (nib)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h00;
      endcase
      // Blank only when this digit and every digit above it are zero.
      blank = (LZB != 0) && (idx_q != '0);
      for (int k = 0; k < DIGITS; k++) begin
         if (k >= int'(idx_q) && bcd_q[4*k +: 4] != 4'd0) blank = 1'b0;
      end
      if (ovf_q)      seg_d = ~7'h40;
      else if (blank) seg_d = 7'h7F;
      else            seg_d = ~pat;
      an_d = ~(DIGITS'(1) << idx_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         scratch_q <= '0;
         ovf_s_q   <= 1'b0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         ref_q     <= '0;
         idx_q     <= '0;
         seg_q     <= 7'b1000000;
         an_q      <= ~DIGITS'(1);
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         ovf_s_q   <= ovf_s_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
         ref_q     <= ref_d;
         idx_q     <= idx_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign overflow = ovf_q;
   assign bcd      = bcd_q;
   assign seg      = seg_q;
   assign an       = an_q;
endmodule
